// File: rtl/cpu_bus1_master_if.sv
// Request/response handshake between the CPU side and the A1/D1/C1 bus master.
// The shared bus wires themselves stay as plain inout ports on the master.
interface cpu_bus1_master_if #(
   parameter int CTR1_BUS_SIZE  = 3,
   parameter int ADDR_W         = 30,
   parameter int DATA1_BUS_SIZE = 16
);
   logic                        req_valid;
   logic                        req_ready;
   logic [CTR1_BUS_SIZE-1:0]    req_cmd;
   logic [ADDR_W-1:0]           req_addr;
   logic [2*DATA1_BUS_SIZE-1:0] req_wdata;
   logic                        resp_valid;
   logic [2*DATA1_BUS_SIZE-1:0] resp_rdata;
   logic                        resp_err;
   logic                        busy;

   // master: the bus-master block's view of the handshake
   modport master (
      input  req_valid, req_cmd, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   // slave: the requester (CPU model or bench) driving commands in
   modport slave (
      output req_valid, req_cmd, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );
endinterface

// File: rtl/cpu_bus1_master.sv
// CPU-side requester for the A1/D1/C1 cache bus. Takes one command at a time,
// serialises command/address/write data onto the bus, releases the bus for a
// one-cycle turnaround, then collects the cache's C1_RESPONSE beats into a
// single response (or flags a timeout).
module cpu_bus1_master #(
   parameter int ADDR1_BUS_SIZE = 15,
   parameter int DATA1_BUS_SIZE = 16,
   parameter int CTR1_BUS_SIZE  = 3,
   parameter int ADDR_BEATS     = 2,
   parameter int TIMEOUT        = 255
) (
   input  logic                      CLK,
   input  logic                      RESET,
   cpu_bus1_master_if.master         cpu,
   inout  wire [ADDR1_BUS_SIZE-1:0]  A1_WIRE,
   inout  wire [DATA1_BUS_SIZE-1:0]  D1_WIRE,
   inout  wire [CTR1_BUS_SIZE-1:0]   C1_WIRE
);

   // C1 encodings; RESPONSE shares its code with WRITE32 because the two
   // only ever appear in opposite bus directions.
   localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8    = CTR1_BUS_SIZE'(1);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16   = CTR1_BUS_SIZE'(2);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32   = CTR1_BUS_SIZE'(3);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8   = CTR1_BUS_SIZE'(5);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16  = CTR1_BUS_SIZE'(6);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32  = CTR1_BUS_SIZE'(7);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE = CTR1_BUS_SIZE'(7);

   localparam int AW       = ADDR_BEATS * ADDR1_BUS_SIZE;
   localparam int DW       = DATA1_BUS_SIZE;
   localparam int MAX_SEND = (ADDR_BEATS > 2) ? ADDR_BEATS : 2;
   localparam int BEAT_W   = $clog2(MAX_SEND);
   localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_TURN, S_WAIT, S_RECV, S_DONE
   } state_t;

   state_t                   state, state_n;
   logic [CTR1_BUS_SIZE-1:0] cmd_q;
   logic [AW-1:0]            addr_q;
   logic [2*DW-1:0]          wdata_q;
   logic [BEAT_W-1:0]        beat;
   logic [BEAT_W-1:0]        send_last;
   logic [TW-1:0]            tcnt;
   logic [DW-1:0]            rx_lo;
   logic [2*DW-1:0]          rdata_q;
   logic                     err_q;
   logic [1:0]               dbw, dbr;
   logic                     rsp_seen, tmo_hit;
   logic                     a_oe, d_oe, c_oe;
   logic [ADDR1_BUS_SIZE-1:0] a_val;
   logic [DW-1:0]            d_val;

   // Write/read data beat counts of the latched command
   always_comb begin
      dbw = 2'd0;
      dbr = 2'd0;
      case (cmd_q)
         C1_WRITE8, C1_WRITE16: dbw = 2'd1;
         C1_WRITE32:            dbw = 2'd2;
         C1_READ8, C1_READ16:   dbr = 2'd1;
         C1_READ32:             dbr = 2'd2;
         default: ;
      endcase
   end

   // Last SEND beat index: max(ADDR_BEATS, write beats) - 1
   always_comb begin
      send_last = BEAT_W'(ADDR_BEATS - 1);
      if (dbw == 2'd2 && ADDR_BEATS < 2) send_last = BEAT_W'(1);
   end

   // Anything other than RESPONSE on C1 (including X/z) is not a response
   assign rsp_seen = (C1_WIRE == C1_RESPONSE);
   assign tmo_hit  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

   // State register; reset also drops every bus driver since they decode state
   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (cpu.req_valid) state_n = S_SEND;
         S_SEND: if (beat == send_last) state_n = S_TURN;
         S_TURN: state_n = S_WAIT;
         S_WAIT: begin
            if (rsp_seen)     state_n = (dbr == 2'd2) ? S_RECV : S_DONE;
            else if (tmo_hit) state_n = S_DONE;
         end
         S_RECV: if (rsp_seen) state_n = S_DONE;
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Request latch, beat/timeout counters and response capture
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         beat    <= '0;
         tcnt    <= '0;
         rx_lo   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu.req_valid) begin
                  cmd_q   <= cpu.req_cmd;
                  addr_q  <= cpu.req_addr;
                  wdata_q <= cpu.req_wdata;
                  beat    <= '0;
               end
            end
            S_SEND: beat <= beat + 1'b1;
            S_TURN: tcnt <= '0;
            S_WAIT: begin
               if (TIMEOUT != 0 && !tmo_hit) tcnt <= tcnt + 1'b1;
               if (rsp_seen) begin
                  err_q <= 1'b0;
                  // rdata_q only changes on the edge into DONE, so it holds
                  // the previous response throughout a two-beat read
                  if (dbr == 2'd2)      rx_lo   <= D1_WIRE;
                  else if (dbr == 2'd1) rdata_q <= {{DW{1'b0}}, D1_WIRE};
                  else                  rdata_q <= '0;
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            S_RECV: if (rsp_seen) rdata_q <= {D1_WIRE, rx_lo};
            default: ;
         endcase
      end
   end

   // Bus drivers: only during SEND, each bus only for the beats it carries
   always_comb begin
      a_oe  = 1'b0;
      d_oe  = 1'b0;
      c_oe  = 1'b0;
      a_val = '0;
      d_val = '0;
      if (state == S_SEND) begin
         c_oe = 1'b1;
         // beat 0 carries the most-significant address chunk
         for (int i = 0; i < ADDR_BEATS; i++) begin
            if (beat == BEAT_W'(i)) begin
               a_oe  = 1'b1;
               a_val = addr_q[(ADDR_BEATS-1-i)*ADDR1_BUS_SIZE +: ADDR1_BUS_SIZE];
            end
         end
         // write data goes low half first
         if (beat == BEAT_W'(0) && dbw != 2'd0) begin
            d_oe  = 1'b1;
            d_val = wdata_q[DW-1:0];
         end
         if (beat == BEAT_W'(1) && dbw == 2'd2) begin
            d_oe  = 1'b1;
            d_val = wdata_q[2*DW-1:DW];
         end
      end
   end

   assign A1_WIRE = a_oe ? a_val : 'z;
   assign D1_WIRE = d_oe ? d_val : 'z;
   assign C1_WIRE = c_oe ? cmd_q : 'z;

   assign cpu.req_ready  = (state == S_IDLE);
   assign cpu.busy       = (state != S_IDLE);
   assign cpu.resp_valid = (state == S_DONE);
   assign cpu.resp_err   = (state == S_DONE) && err_q;
   assign cpu.resp_rdata = rdata_q;

endmodule

// File: tb/tb_cpu_bus1_master.sv
// Bench for cpu_bus1_master. Two instances: A (ADDR_BEATS=2, TIMEOUT=4) and
// B (ADDR_BEATS=3, TIMEOUT=0). A cycle-level transaction model plays the
// cache and predicts every bus beat and response. Whenever the master should
// have released a bus, the bench drives that bus itself (0, or the cache's
// response), so a master that keeps driving shows up as a corrupted value.
module tb_cpu_bus1_master;

   localparam logic [2:0] C_RD8 = 3'd1, C_RD16 = 3'd2, C_RD32 = 3'd3, C_INV = 3'd4;
   localparam logic [2:0] C_WR8 = 3'd5, C_WR16 = 3'd6, C_WR32 = 3'd7, C_RESP = 3'd7;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic        sel = 1'b0;          // 0: instance A active, 1: instance B
   logic        tb_valid = 1'b0;
   logic [2:0]  tb_cmd = '0;
   logic [44:0] tb_addr = '0;
   logic [31:0] tb_wdata = '0;
   logic        en_a = 1'b1, en_d = 1'b1, en_c = 1'b1;
   logic [15:0] val_d = '0;
   logic [2:0]  val_c = '0;

   cpu_bus1_master_if #(.CTR1_BUS_SIZE(3), .ADDR_W(30), .DATA1_BUS_SIZE(16)) ifa ();
   cpu_bus1_master_if #(.CTR1_BUS_SIZE(3), .ADDR_W(45), .DATA1_BUS_SIZE(16)) ifb ();

   wire [14:0] a1_a, a1_b;
   wire [15:0] d1_a, d1_b;
   wire [2:0]  c1_a, c1_b;

   cpu_bus1_master #(.ADDR_BEATS(2), .TIMEOUT(4)) dut_a (
      .CLK(CLK), .RESET(RESET), .cpu(ifa),
      .A1_WIRE(a1_a), .D1_WIRE(d1_a), .C1_WIRE(c1_a));

   cpu_bus1_master #(.ADDR_BEATS(3), .TIMEOUT(0)) dut_b (
      .CLK(CLK), .RESET(RESET), .cpu(ifb),
      .A1_WIRE(a1_b), .D1_WIRE(d1_b), .C1_WIRE(c1_b));

   assign ifa.req_valid = tb_valid & ~sel;
   assign ifa.req_cmd   = tb_cmd;
   assign ifa.req_addr  = tb_addr[29:0];
   assign ifa.req_wdata = tb_wdata;
   assign ifb.req_valid = tb_valid & sel;
   assign ifb.req_cmd   = tb_cmd;
   assign ifb.req_addr  = tb_addr;
   assign ifb.req_wdata = tb_wdata;

   // Cache side of each bus; the idle instance is always held at 0
   assign a1_a = (sel || en_a) ? 15'd0 : 'z;
   assign d1_a = (sel || en_d) ? (sel ? 16'd0 : val_d) : 'z;
   assign c1_a = (sel || en_c) ? (sel ? 3'd0 : val_c) : 'z;
   assign a1_b = (!sel || en_a) ? 15'd0 : 'z;
   assign d1_b = (!sel || en_d) ? (!sel ? 16'd0 : val_d) : 'z;
   assign c1_b = (!sel || en_c) ? (!sel ? 3'd0 : val_c) : 'z;

   wire [14:0] a1_o   = sel ? a1_b : a1_a;
   wire [15:0] d1_o   = sel ? d1_b : d1_a;
   wire [2:0]  c1_o   = sel ? c1_b : c1_a;
   wire        rdy_o  = sel ? ifb.req_ready  : ifa.req_ready;
   wire        busy_o = sel ? ifb.busy       : ifa.busy;
   wire        rv_o   = sel ? ifb.resp_valid : ifa.resp_valid;
   wire        rerr_o = sel ? ifb.resp_err   : ifa.resp_err;
   wire [31:0] rd_o   = sel ? ifb.resp_rdata : ifa.resp_rdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int wr_beats(input logic [2:0] c);
      if (c == C_WR8 || c == C_WR16) return 1;
      if (c == C_WR32) return 2;
      return 0;
   endfunction

   function automatic int rd_beats(input logic [2:0] c);
      if (c == C_RD8 || c == C_RD16) return 1;
      if (c == C_RD32) return 2;
      return 0;
   endfunction

   // Address chunk k of an ab-beat address, most-significant chunk first
   function automatic logic [14:0] chunk(input logic [44:0] a, input int ab, input int k);
      logic [44:0] s;
      s = a >> ((ab - 1 - k) * 15);
      return s[14:0];
   endfunction

   // Non-response garbage for the cache side while the master listens
   task automatic garbage();
      val_c = 3'($urandom_range(0, 6));
      val_d = 16'($urandom);
   endtask

   // One full transaction on the active instance. Entered and left at a
   // negedge with the master idle. dly: WAIT cycles before the first
   // RESPONSE; gap: cycles before the second read beat; poke: SEND beat
   // during which req_valid is raised again (-1 for none).
   task automatic txn(input logic [2:0] cmd, input logic [44:0] addr, input logic [31:0] wd,
                      input int dly, input int gap, input logic [15:0] r0,
                      input logic [15:0] r1, input int poke);
      int ab, to, nw, nr, nsend;
      logic got, exp_err;
      logic [31:0] exp_rd;
      logic [15:0] ed;
      ab = sel ? 3 : 2;
      to = sel ? 0 : 4;
      nw = wr_beats(cmd);
      nr = rd_beats(cmd);
      nsend = (ab > nw) ? ab : nw;
      chk("idle_ready", {rdy_o, busy_o}, 2'b10);
      tb_cmd = cmd; tb_addr = addr; tb_wdata = wd; tb_valid = 1'b1;
      for (int k = 0; k < nsend; k++) begin
         @(posedge CLK); #1;
         tb_valid = (k == poke);
         en_a = (k >= ab); en_d = (k >= nw); en_c = 1'b0; val_c = '0; val_d = '0;
         @(negedge CLK);
         ed = (k < nw) ? wd[16*k +: 16] : 16'h0;
         chk("send_c1", c1_o, cmd);
         chk("send_a1", a1_o, (k < ab) ? chunk(addr, ab, k) : 15'h0);
         chk("send_d1", d1_o, ed);
         chk("send_st", {rdy_o, busy_o, rv_o}, 3'b010);
      end
      // turnaround: everything released, cache not yet talking
      @(posedge CLK); #1;
      tb_valid = 1'b0; en_a = 1'b1; en_d = 1'b1; en_c = 1'b1; val_c = '0; val_d = '0;
      @(negedge CLK);
      chk("turn_bus", {a1_o, d1_o, c1_o}, 34'h0);
      chk("turn_st", {rdy_o, busy_o, rv_o}, 3'b010);
      got = 1'b0; exp_err = 1'b0;
      for (int w = 0; ; w++) begin
         @(posedge CLK); #1;
         if (w == dly) begin val_c = C_RESP; val_d = r0; end
         else garbage();
         @(negedge CLK);
         chk("wait_st", {rdy_o, busy_o, rv_o}, 3'b010);
         if (w == dly) begin got = 1'b1; break; end
         if (to != 0 && w == to - 1) begin exp_err = 1'b1; break; end
      end
      if (got && nr == 2) begin
         for (int g = 0; ; g++) begin
            @(posedge CLK); #1;
            if (g == gap) begin val_c = C_RESP; val_d = r1; end
            else garbage();
            @(negedge CLK);
            chk("recv_st", {rdy_o, busy_o, rv_o}, 3'b010);
            if (g == gap) break;
         end
      end
      @(posedge CLK); #1;
      val_c = '0; val_d = '0;
      @(negedge CLK);
      if (!got || nr == 0) exp_rd = 32'h0;
      else if (nr == 1)    exp_rd = {16'h0, r0};
      else                 exp_rd = {r1, r0};
      chk("done_st", {rdy_o, busy_o, rv_o}, 3'b011);
      chk("done_err", rerr_o, exp_err);
      chk("done_rdata", rd_o, exp_rd);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("after_st", {rdy_o, busy_o, rv_o, rerr_o}, 4'b1000);
      chk("rdata_hold", rd_o, exp_rd);
   endtask

   initial begin
      logic [44:0] ra;
      // reset for two edges, both instances idle and released
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_a_st", {rdy_o, busy_o, rv_o, rerr_o}, 4'b1000);
      chk("rst_a_rd", rd_o, 32'h0);
      chk("rst_a_bus", {a1_o, d1_o, c1_o}, 34'h0);
      sel = 1'b1; #1;
      chk("rst_b_st", {rdy_o, busy_o, rv_o, rerr_o}, 4'b1000);
      sel = 1'b0;
      RESET = 1'b0;

      // directed cases on instance A
      txn(C_INV,  45'({15'd1, 15'd2}),    32'h0,        2, 0, 16'h0,    16'h0,    -1);
      txn(C_WR32, 45'({15'h0aa, 15'h155}), 32'h12345678, 0, 0, 16'h0,    16'h0,    -1);
      txn(C_RD32, 45'({15'h10, 15'h4}),   32'h0,        0, 1, 16'hBEEF, 16'hDEAD, -1);
      // no cache answer: error after exactly TIMEOUT wait cycles
      txn(C_RD8,  45'({15'h3, 15'h7}),    32'h0,        99, 0, 16'h0,   16'h0,    -1);
      txn(C_RD16, 45'({15'h21, 15'h42}),  32'h0,        1, 0, 16'hCAFE, 16'h0,    -1);

      // reset during SEND beat 1 discards the transfer
      ra = 45'({15'h1234, 15'h0567});
      tb_cmd = C_RD32; tb_addr = ra; tb_valid = 1'b1;
      @(posedge CLK); #1;
      tb_valid = 1'b0; en_a = 1'b0; en_d = 1'b1; en_c = 1'b0;
      @(negedge CLK);
      chk("rst_mid_a1_0", a1_o, chunk(ra, 2, 0));
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst_mid_a1_1", a1_o, chunk(ra, 2, 1));
      RESET = 1'b1;
      @(posedge CLK); #1;
      en_a = 1'b1; en_c = 1'b1; val_c = '0; val_d = '0;
      @(negedge CLK);
      chk("rst_mid_bus", {a1_o, d1_o, c1_o}, 34'h0);
      chk("rst_mid_st", {rdy_o, busy_o, rv_o, rerr_o}, 4'b1000);
      chk("rst_mid_rd", rd_o, 32'h0);
      RESET = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1;
         val_c = C_RESP; val_d = 16'h5555;
         @(negedge CLK);
         chk("rst_mid_quiet", {rv_o, busy_o}, 2'b00);
      end
      val_c = '0; val_d = '0;
      txn(C_RD32, 45'({15'h77, 15'h99}), 32'h0, 0, 0, 16'h1111, 16'h2222, -1);

      // randomized traffic on A (delays 4 and 5 run into the timeout)
      for (int i = 0; i < 14; i++) begin
         ra = {15'h0, 15'($urandom), 15'($urandom)};
         txn(3'($urandom_range(1, 7)), ra, $urandom, $urandom_range(0, 5),
             $urandom_range(0, 2), 16'($urandom), 16'($urandom), -1);
      end

      // instance B: three address beats, write data only in beat 0, and a
      // request raised mid-transfer must not start a second transaction
      sel = 1'b1; #1;
      txn(C_WR8, 45'({15'h7001, 15'h0002, 15'h0003}), 32'h0000A5C3, 1, 0, 16'h0, 16'h0, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("b_no_second", {rdy_o, busy_o}, 2'b10);
      end
      // TIMEOUT=0 never gives up, even on a slow cache
      txn(C_RD32, 45'({15'h1, 15'h2, 15'h3}), 32'h0, 9, 2, 16'h0F0F, 16'hF0F0, -1);
      for (int i = 0; i < 6; i++) begin
         ra = {15'($urandom), 15'($urandom), 15'($urandom)};
         txn(3'($urandom_range(1, 7)), ra, $urandom, $urandom_range(0, 8),
             $urandom_range(0, 2), 16'($urandom), 16'($urandom), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_bus1_master.md
Name: cpu_bus1_master

Overview:
- CPU-side requester for the CPU–cache bus (A1/D1/C1).
- Accepts one command at a time on a valid/ready request port and serialises it onto the shared bus: command plus multi-beat address, with write data alongside.
- Releases the bus, waits for the cache's C1_RESPONSE beats, collects read data and returns a single response.
- Replaces hand-driven bus stimulus in benches and is the bus port of the future CPU model. Generalised in address beat count, data width and response timeout.

Parameters:
ADDR1_BUS_SIZE, 15, width of A1 bus per beat
DATA1_BUS_SIZE, 16, width of D1 bus per beat
CTR1_BUS_SIZE, 3, width of C1 bus
ADDR_BEATS, 2, address beats per command (beat 0 = most-significant chunk)
TIMEOUT, 255, max cycles waiting for first C1_RESPONSE before error (0 = never)

Ports:
CLK  input  1  clock; all state changes on rising edge
RESET  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_cmd  input  CTR1_BUS_SIZE  C1 command code (READ8/16/32, WRITE8/16/32, INVALIDATE_LINE)
req_addr  input  ADDR_BEATS*ADDR1_BUS_SIZE  full address
req_wdata  input  2*DATA1_BUS_SIZE  write data; low beat sent first
A1_WIRE  inout  ADDR1_BUS_SIZE  address bus; driven only while sending, else 'z
D1_WIRE  inout  DATA1_BUS_SIZE  data bus; driven only during write data beats, else 'z
C1_WIRE  inout  CTR1_BUS_SIZE  control bus; driven only while sending, else 'z
resp_valid  output  1  one-cycle pulse: response complete
resp_rdata  output  2*DATA1_BUS_SIZE  read data; low beat = first received
resp_err  output  1  qualifies resp_valid: timeout occurred
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high): next edge → IDLE; A1/D1/C1 drivers 'z; resp_valid=0, resp_err=0, resp_rdata=0, busy=0, req_ready=1. Applies mid-transfer: the bus is released on that same edge and the partial transaction is discarded with no response.
- Beat counts:
  - DBW (write data beats) = 1 for WRITE8/16, 2 for WRITE32, else 0.
  - DBR (read data beats) = 1 for READ8/16, 2 for READ32, else 0.
  - SEND = max(ADDR_BEATS, DBW).
- States and transitions:
  - IDLE: on req_valid && req_ready, latch cmd/addr/wdata → SEND.
  - SEND (SEND cycles):
    - Beat k drives C1=cmd.
    - A1 = address chunk k while k<ADDR_BEATS, else 'z.
    - D1 = wdata beat k while k<DBW, else 'z.
    - After the last beat → TURN.
  - TURN (1 cycle): all drivers 'z; the timeout counter is cleared → WAIT.
  - WAIT: sample C1_WIRE each edge.
    - C1==C1_RESPONSE with DBR>0: capture D1 as beat 0 → RECV if DBR=2, else DONE.
    - C1==C1_RESPONSE with DBR=0 (writes, invalidate): → DONE.
    - Counter reaches TIMEOUT (TIMEOUT≠0): → DONE with err.
  - RECV: capture D1 as beat 1 on the next cycle with C1==C1_RESPONSE (no timeout in RECV) → DONE.
  - DONE (1 cycle): resp_valid=1, resp_err as set, resp_rdata valid (unused beats 0) → IDLE.
- Latency: a request accepted at edge N drives its first beat from edge N+1. Minimum request-to-resp_valid latency is SEND+DBR_or_1+2 cycles after the cache responds immediately.
- Bus values on C1/A1/D1 other than C1_RESPONSE during WAIT/RECV are ignored, including X/z.
- req_valid is ignored while busy; no queuing.
- Never drives C1 and samples it in the same cycle; the one-cycle TURN gap is mandatory even if the cache is faster.
- resp_rdata holds its value until the next DONE.

Test Plan:
- Bench sequence: RESET=1 for 2 edges, then req INVALIDATE_LINE, addr=(1,2) → C1=INVALIDATE_LINE with A1=1 then A1=2 on consecutive edges; 'z in TURN; cache drives C1_RESPONSE 2 cycles later → resp_valid=1, resp_err=0, resp_rdata=0.
- READ32 addr=(0x10,0x4): cache returns D1=0xBEEF then 0xDEAD on two RESPONSE cycles separated by a 1-cycle gap → resp_rdata=0xDEADBEEF.
- WRITE32 wdata=0x12345678, ADDR_BEATS=2 → D1=0x5678 in beat 0 and 0x1234 in beat 1 alongside A1; D1 'z afterwards; one RESPONSE → resp_valid, no data.
- TIMEOUT=4, READ8 with no cache response → resp_valid with resp_err=1 exactly 4 cycles after entering WAIT; busy drops the following cycle.
- RESET asserted during SEND beat 1 → all buses 'z on the same edge, no resp_valid ever pulses, req_ready=1; a subsequent request completes normally.
- ADDR_BEATS=3, WRITE8 → 3 SEND beats, D1 driven only in beat 0; req_valid pulsed while busy is ignored (no second transaction).
